// File: rtl/mem_pkg.sv
// Shared types and constants for the boot-ROM / data-RAM arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] ROM_LIMIT_DEFAULT  = 32'h0000_00FF;
  localparam int unsigned       STARVE_MAX_DEFAULT = 4;
  localparam int unsigned       CNT_W_DEFAULT      = 3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_EX = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_write;
  } owner_tag_t;

  function automatic logic is_rom(input logic [ADDR_W-1:0] addr,
                                  input logic [ADDR_W-1:0] limit);
    return addr <= limit;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of mem_arbiter.
// ex_err exists only when MEM_ARB_ERR_EN is defined.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ex_req;
  logic              ex_we;
  logic [BE_W-1:0]   ex_be;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_gnt;
  logic              ex_rvalid;
  logic [DATA_W-1:0] ex_rdata;
`ifdef MEM_ARB_ERR_EN
  logic              ex_err;
`endif

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Requesters and memories drive this side.
  modport master (
    output if_req, if_addr, ex_req, ex_we, ex_be, ex_addr, ex_wdata,
    output rom_rdata, ram_rdata,
`ifdef MEM_ARB_ERR_EN
    input  ex_err,
`endif
    input  if_gnt, if_rvalid, if_rdata, ex_gnt, ex_rvalid, ex_rdata,
    input  rom_en, rom_addr, ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  // The arbiter sits on this side.
  modport slave (
    input  if_req, if_addr, ex_req, ex_we, ex_be, ex_addr, ex_wdata,
    input  rom_rdata, ram_rdata,
`ifdef MEM_ARB_ERR_EN
    output ex_err,
`endif
    output if_gnt, if_rvalid, if_rdata, ex_gnt, ex_rvalid, ex_rdata,
    output rom_en, rom_addr, ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_resp_track.sv
// Per-memory owner tag: remembers who was granted last cycle and steers
// that memory's read data to the owning port.
module mem_resp_track
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  owner_tag_t        issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_rvalid_c,
  output logic [DATA_W-1:0] if_rdata_c,
  output logic              ex_rvalid_c,
  output logic [DATA_W-1:0] ex_rdata_c
);

  owner_tag_t tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag <= '0;
    else     tag <= issue;
  end

  // Writes (including dropped ROM writes) complete with zero data.
  always_comb begin
    if_rvalid_c = 1'b0;
    if_rdata_c  = '0;
    ex_rvalid_c = 1'b0;
    ex_rdata_c  = '0;
    if (tag.valid) begin
      if (tag.port == PORT_IF) begin
        if_rvalid_c = 1'b1;
        if_rdata_c  = tag.is_write ? '0 : mem_rdata;
      end else begin
        ex_rvalid_c = 1'b1;
        ex_rdata_c  = tag.is_write ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares boot ROM and data RAM between the IF and EX ports with IF
// starvation protection. Define MEM_ARB_ERR_EN to add the ex_err output.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROM_LIMIT  = ROM_LIMIT_DEFAULT,
  parameter int unsigned       STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned       CNT_W      = CNT_W_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  logic             if_rom, ex_rom, conflict, if_wins;
  logic             if_gnt_c, ex_gnt_c;
  logic             if_on_rom, if_on_ram, ex_on_rom, ex_on_ram;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  owner_tag_t       rom_issue, ram_issue;

  logic              rom_if_v, rom_ex_v, ram_if_v, ram_ex_v;
  logic [DATA_W-1:0] rom_if_d, rom_ex_d, ram_if_d, ram_ex_d;

  // Decode and grant; EX wins same-target conflicts unless IF is starved.
  always_comb begin
    if_rom    = is_rom(bus.if_addr, ROM_LIMIT);
    ex_rom    = is_rom(bus.ex_addr, ROM_LIMIT);
    conflict  = bus.if_req && bus.ex_req && (if_rom == ex_rom);
    if_wins   = (starve_cnt == CNT_W'(STARVE_MAX));
    if_gnt_c  = !rst && bus.if_req && (!conflict || if_wins);
    ex_gnt_c  = !rst && bus.ex_req && (!conflict || !if_wins);
    if_on_rom = if_gnt_c && if_rom;
    if_on_ram = if_gnt_c && !if_rom;
    ex_on_rom = ex_gnt_c && ex_rom;
    ex_on_ram = ex_gnt_c && !ex_rom;
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!bus.if_req || if_gnt_c)
      starve_cnt_nxt = '0;
    else if (conflict && (starve_cnt != CNT_W'(STARVE_MAX)))
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt <= '0;
    else     starve_cnt <= starve_cnt_nxt;
  end

  // Memory drive; an EX write to ROM is acknowledged but never reaches it.
  always_comb begin
    bus.if_gnt    = if_gnt_c;
    bus.ex_gnt    = ex_gnt_c;
    bus.rom_en    = if_on_rom || (ex_on_rom && !bus.ex_we);
    bus.rom_addr  = ex_on_rom ? bus.ex_addr : bus.if_addr;
    bus.ram_en    = if_on_ram || ex_on_ram;
    bus.ram_we    = ex_on_ram && bus.ex_we;
    bus.ram_be    = ex_on_ram ? bus.ex_be : '0;
    bus.ram_addr  = ex_on_ram ? bus.ex_addr : bus.if_addr;
    bus.ram_wdata = ex_on_ram ? bus.ex_wdata : '0;
  end

  always_comb begin
    rom_issue.valid    = if_on_rom || ex_on_rom;
    rom_issue.port     = ex_on_rom ? PORT_EX : PORT_IF;
    rom_issue.is_write = ex_on_rom && bus.ex_we;
    ram_issue.valid    = if_on_ram || ex_on_ram;
    ram_issue.port     = ex_on_ram ? PORT_EX : PORT_IF;
    ram_issue.is_write = ex_on_ram && bus.ex_we;
  end

  mem_resp_track u_rom_track (
    .clk         (clk),
    .rst         (rst),
    .issue       (rom_issue),
    .mem_rdata   (bus.rom_rdata),
    .if_rvalid_c (rom_if_v),
    .if_rdata_c  (rom_if_d),
    .ex_rvalid_c (rom_ex_v),
    .ex_rdata_c  (rom_ex_d)
  );

  mem_resp_track u_ram_track (
    .clk         (clk),
    .rst         (rst),
    .issue       (ram_issue),
    .mem_rdata   (bus.ram_rdata),
    .if_rvalid_c (ram_if_v),
    .if_rdata_c  (ram_if_d),
    .ex_rvalid_c (ram_ex_v),
    .ex_rdata_c  (ram_ex_d)
  );

  always_comb begin
    bus.if_rvalid = rom_if_v | ram_if_v;
    bus.if_rdata  = rom_if_d | ram_if_d;
    bus.ex_rvalid = rom_ex_v | ram_ex_v;
    bus.ex_rdata  = rom_ex_d | ram_ex_d;
  end

`ifdef MEM_ARB_ERR_EN
  logic ex_err_q;

  // ROM write, or misaligned read / full-word write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_err_q <= 1'b0;
    else     ex_err_q <= ex_gnt_c &&
                         ((bus.ex_we && ex_rom) ||
                          ((bus.ex_addr[1:0] != 2'b00) &&
                           (!bus.ex_we || (bus.ex_be == 4'b1111))));
  end

  always_comb bus.ex_err = ex_err_q;
`endif

endmodule
